cnt_ctrl: RTL and testbench
===========================

Name: cnt_ctrl

Overview:
Sequences the timer's main counter from the TCR configuration fields (timer_en, div_en, div_val).
- Contains the prescaler (divide by 2^div_val), the CNT_WIDTH-bit up-counter, a debug halt handshake and software load of the counter.
- Sits between the TCR register and the compare/interrupt logic, which consume cnt, tick and ovf.

Parameters:
CNT_WIDTH, 64, width of main counter
DIV_MAX, 8, largest legal div_val; larger inputs are clamped to this value
PRE_WIDTH, 8, prescaler counter width; must satisfy 2^PRE_WIDTH >= 2^DIV_MAX

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high (one clock; polarity and synchronicity fixed)
timer_en  in  1  TCR.timer_en
div_en  in  1  TCR.div_en
div_val  in  4  TCR.div_val, legal range 0..DIV_MAX
halt_req  in  1  debug halt request, level
halt_ack  out  1  high while counting is frozen by halt
cnt_ld  in  1  one-cycle load strobe from register block
cnt_ld_data  in  CNT_WIDTH  load value
cnt  out  CNT_WIDTH  current counter value
tick  out  1  registered one-cycle pulse, coincident with each counter increment
ovf  out  1  registered one-cycle pulse when cnt wraps from all-ones to 0

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, pre_cnt=0, cnt=0, tick=0, ovf=0, halt_ack=0.
- Prescaler limit:
  - div_en=0: limit=0, one increment per clk.
  - div_en=1: limit = 2^min(div_val,DIV_MAX) - 1.
- FSM states are IDLE, RUN and HALT. In IDLE, pre_cnt is held at 0.
- IDLE -> RUN: when timer_en=1. The first increment occurs limit+1 cycles after the edge where timer_en is sampled 1.
- RUN, per cycle:
  - If pre_cnt >= limit: pre_cnt<=0, cnt<=cnt+1 (modulo 2^CNT_WIDTH), tick<=1.
  - Otherwise: pre_cnt<=pre_cnt+1.
  - The >= comparison absorbs a limit decrease made mid-run.
- ovf<=1 in the same cycle tick<=1 when the old cnt is all-ones; cnt becomes 0.
- RUN -> HALT: when halt_req=1. The halt takes effect at that edge: no increment that cycle, pre_cnt and cnt frozen, halt_ack<=1.
- HALT -> RUN: when halt_req=0 and timer_en=1. halt_ack<=0 at that edge and the prescaler resumes from its held pre_cnt value.
- RUN or HALT -> IDLE: when timer_en=0. This takes priority over halt. At that edge cnt<=0, pre_cnt<=0, halt_ack<=0 and there is no tick.
- halt_req in IDLE: ignored; halt_ack stays 0.
- cnt_ld=1: cnt<=cnt_ld_data in every state.
  - Load has priority over both the increment and the timer_en-fall clear.
  - A tick due in the same cycle is dropped: tick=0, ovf=0. pre_cnt still wraps or advances normally.
- tick and ovf are registered and never high for two consecutive cycles when limit>0.
- There is no combinational path from any input to any output.

Decomposition:
- Shared package ictc_pkg holds:
  - the state enum (CC_IDLE, CC_RUN, CC_HALT);
  - localparams CNT_WIDTH_DEF=64 and DIV_MAX_DEF=8.
- One natural sub-module, cnt_prescaler, owns the pre_cnt register, the limit decode and clamp, and the wrap compare. Its interface is run/clear in and wrap pulse out.
- The FSM, main counter, load mux, and tick/ovf registers live in cnt_ctrl.

Test Plan:
- Reset then timer_en=1, div_en=0 -> tick every cycle starting 1 cycle later; cnt=1,2,3 on consecutive cycles; halt_ack=0.
- div_en=1, div_val=3, timer_en=1 for 40 cycles -> tick every 8 cycles, first tick at cycle 8; cnt=5 after 40 cycles.
- div_val=9 with div_en=1 -> clamped to 8; tick period 256 cycles.
- cnt_ld with cnt_ld_data=0xFFFF_FFFF_FFFF_FFFE, div_en=0, running -> cnt=...FE then FF then 0 with ovf=1 on that cycle; next cycle ovf=0 and cnt=1.
- div_val=2, halt_req raised when pre_cnt=2 for 10 cycles, then released -> halt_ack=1 for exactly those cycles, cnt unchanged; next tick occurs 2 cycles after release.
- Running with cnt=0x10: drop timer_en and assert cnt_ld=1 with cnt_ld_data=0x55 in the same cycle -> cnt=0x55, state IDLE, no tick. Then assert rst mid-run -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/ictc_pkg.sv
// ictc_pkg: shared state encoding, default sizes and div_val clamp for the timer counter control
package ictc_pkg;

    typedef enum logic [1:0] {
        CC_IDLE,
        CC_RUN,
        CC_HALT
    } cc_state_e;

    localparam int CNT_WIDTH_DEF = 64;
    localparam int DIV_MAX_DEF   = 8;

    function automatic logic [3:0] clamp_div(input logic [3:0] v, input logic [3:0] m);
        return (v > m) ? m : v;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: divide-by-2^div_val prescaler; wrap_o marks the cycle the main counter may advance
module cnt_prescaler
    import ictc_pkg::*;
#(
    parameter int DIV_MAX   = DIV_MAX_DEF,
    parameter int PRE_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_i,
    input  logic       clear_i,
    input  logic       div_en_i,
    input  logic [3:0] div_val_i,
    output logic       wrap_o
);

    logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d, limit;
    logic [3:0]           dv;

    always_comb begin
        dv    = clamp_div(div_val_i, 4'(DIV_MAX));
        limit = div_en_i ? ~({PRE_WIDTH{1'b1}} << dv) : '0;
        // >= rather than == so a limit lowered mid-run wraps at once
        wrap_o    = run_i && (pre_cnt_q >= limit);
        pre_cnt_d = clear_i ? '0 :
                    wrap_o  ? '0 :
                    run_i   ? pre_cnt_q + PRE_WIDTH'(1) : pre_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pre_cnt_q <= '0;
        else     pre_cnt_q <= pre_cnt_d;
    end

endmodule

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: timer main counter with prescaler, debug halt handshake and software load
module cnt_ctrl
    import ictc_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int DIV_MAX   = DIV_MAX_DEF,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 timer_en_i,
    input  logic                 div_en_i,
    input  logic [3:0]           div_val_i,
    input  logic                 halt_req_i,
    output logic                 halt_ack_o,
    input  logic                 cnt_ld_i,
    input  logic [CNT_WIDTH-1:0] cnt_ld_data_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 tick_o,
    output logic                 ovf_o
);

    cc_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tick_q, tick_d, ovf_q, ovf_d, ack_q, ack_d;
    logic                 run, clear, wrap, leave;

    cnt_prescaler #(.DIV_MAX(DIV_MAX), .PRE_WIDTH(PRE_WIDTH)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .run_i    (run),
        .clear_i  (clear),
        .div_en_i (div_en_i),
        .div_val_i(div_val_i),
        .wrap_o   (wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            CC_IDLE: state_d = timer_en_i ? CC_RUN : CC_IDLE;
            CC_RUN:  state_d = !timer_en_i ? CC_IDLE : halt_req_i ? CC_HALT : CC_RUN;
            CC_HALT: state_d = !timer_en_i ? CC_IDLE : halt_req_i ? CC_HALT : CC_RUN;
            default: state_d = CC_IDLE;
        endcase
        // timer_en fall beats halt; load beats both increment and clear
        leave  = (state_q != CC_IDLE) && !timer_en_i;
        run    = (state_q == CC_RUN) && timer_en_i && !halt_req_i;
        clear  = (state_q == CC_IDLE) || !timer_en_i;
        tick_d = wrap && !cnt_ld_i;
        ovf_d  = tick_d && (&cnt_q);
        ack_d  = (state_d == CC_HALT);
        cnt_d  = cnt_ld_i ? cnt_ld_data_i :
                 leave    ? '0 :
                 tick_d   ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CC_IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign tick_o     = tick_q;
    assign ovf_o      = ovf_q;
    assign halt_ack_o = ack_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: directed self-checking bench for cnt_ctrl; inputs driven and outputs sampled on negedge
module tb_cnt_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        timer_en = 1'b0;
    logic        div_en = 1'b0;
    logic [3:0]  div_val = 4'd0;
    logic        halt_req = 1'b0;
    logic        halt_ack;
    logic        cnt_ld = 1'b0;
    logic [63:0] cnt_ld_data = 64'd0;
    logic [63:0] cnt;
    logic        tick;
    logic        ovf;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cnt_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .timer_en_i   (timer_en),
        .div_en_i     (div_en),
        .div_val_i    (div_val),
        .halt_req_i   (halt_req),
        .halt_ack_o   (halt_ack),
        .cnt_ld_i     (cnt_ld),
        .cnt_ld_data_i(cnt_ld_data),
        .cnt_o        (cnt),
        .tick_o       (tick),
        .ovf_o        (ovf)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        checks++;
        if ({cnt, tick, ovf, halt_ack} !== 67'd0) begin
            errors++;
            $display("FAIL reset: cnt=%h tick=%b ovf=%b ack=%b, want all 0", cnt, tick, ovf, halt_ack);
        end
    endtask

    task automatic test_nodiv;
        timer_en = 1'b1;
        div_en   = 1'b0;
        step(1);
        checks++;
        if (cnt !== 64'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL nodiv_start: cnt=%0d tick=%b, want 0 0", cnt, tick);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1);
            checks++;
            if (cnt !== 64'(i) || tick !== 1'b1 || halt_ack !== 1'b0) begin
                errors++;
                $display("FAIL nodiv_%0d: cnt=%0d tick=%b ack=%b, want %0d 1 0", i, cnt, tick, halt_ack, i);
            end
        end
        timer_en = 1'b0;
        step(1);
        checks++;
        if (cnt !== 64'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL nodiv_stop: cnt=%0d tick=%b, want 0 0", cnt, tick);
        end
    endtask

    task automatic test_div;
        div_en   = 1'b1;
        div_val  = 4'd3;
        timer_en = 1'b1;
        step(1);
        for (int k = 1; k <= 40; k++) begin
            step(1);
            checks++;
            if (tick !== (k % 8 == 0) || cnt !== 64'(k / 8)) begin
                errors++;
                $display("FAIL div8_c%0d: cnt=%0d tick=%b, want %0d %b", k, cnt, tick, k / 8, k % 8 == 0);
            end
        end
        timer_en = 1'b0;
        step(1);
    endtask

    task automatic test_clamp;
        div_en   = 1'b1;
        div_val  = 4'd9;
        timer_en = 1'b1;
        step(1);
        for (int k = 1; k <= 512; k++) begin
            step(1);
            if (k == 255 || k == 256 || k == 511 || k == 512) begin
                checks++;
                if (tick !== (k % 256 == 0) || cnt !== 64'(k / 256)) begin
                    errors++;
                    $display("FAIL clamp_c%0d: cnt=%0d tick=%b, want %0d %b", k, cnt, tick, k / 256, k % 256 == 0);
                end
            end
        end
        timer_en = 1'b0;
        step(1);
    endtask

    task automatic test_load_wrap;
        div_en   = 1'b0;
        timer_en = 1'b1;
        step(1);
        cnt_ld      = 1'b1;
        cnt_ld_data = 64'hFFFF_FFFF_FFFF_FFFE;
        step(1);
        cnt_ld = 1'b0;
        checks++;
        if (cnt !== 64'hFFFF_FFFF_FFFF_FFFE || tick !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL load: cnt=%h tick=%b ovf=%b, want fffffffffffffffe 0 0", cnt, tick, ovf);
        end
        step(1);
        checks++;
        if (cnt !== 64'hFFFF_FFFF_FFFF_FFFF || tick !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL pre_wrap: cnt=%h tick=%b ovf=%b, want ffffffffffffffff 1 0", cnt, tick, ovf);
        end
        step(1);
        checks++;
        if (cnt !== 64'd0 || tick !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap: cnt=%h tick=%b ovf=%b, want 0 1 1", cnt, tick, ovf);
        end
        step(1);
        checks++;
        if (cnt !== 64'd1 || tick !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL post_wrap: cnt=%h tick=%b ovf=%b, want 1 1 0", cnt, tick, ovf);
        end
        timer_en = 1'b0;
        step(1);
    endtask

    task automatic test_halt;
        div_en   = 1'b1;
        div_val  = 4'd2;
        timer_en = 1'b1;
        step(3);
        halt_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            checks++;
            if (halt_ack !== 1'b1 || cnt !== 64'd0 || tick !== 1'b0) begin
                errors++;
                $display("FAIL halt_c%0d: ack=%b cnt=%0d tick=%b, want 1 0 0", k, halt_ack, cnt, tick);
            end
        end
        halt_req = 1'b0;
        step(1);
        checks++;
        if (halt_ack !== 1'b0 || cnt !== 64'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL release: ack=%b cnt=%0d tick=%b, want 0 0 0", halt_ack, cnt, tick);
        end
        step(1);
        checks++;
        if (tick !== 1'b0 || cnt !== 64'd0) begin
            errors++;
            $display("FAIL resume1: cnt=%0d tick=%b, want 0 0", cnt, tick);
        end
        step(1);
        checks++;
        if (tick !== 1'b1 || cnt !== 64'd1) begin
            errors++;
            $display("FAIL resume2: cnt=%0d tick=%b, want 1 1", cnt, tick);
        end
        timer_en = 1'b0;
        step(1);
        halt_req = 1'b1;
        step(2);
        checks++;
        if (halt_ack !== 1'b0 || cnt !== 64'd0) begin
            errors++;
            $display("FAIL idle_halt: ack=%b cnt=%0d, want 0 0", halt_ack, cnt);
        end
        halt_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        div_en   = 1'b0;
        timer_en = 1'b1;
        step(17);
        checks++;
        if (cnt !== 64'h10) begin
            errors++;
            $display("FAIL run_to_10: cnt=%h, want 10", cnt);
        end
        timer_en    = 1'b0;
        cnt_ld      = 1'b1;
        cnt_ld_data = 64'h55;
        step(1);
        cnt_ld = 1'b0;
        checks++;
        if (cnt !== 64'h55 || tick !== 1'b0) begin
            errors++;
            $display("FAIL ld_over_clear: cnt=%h tick=%b, want 55 0", cnt, tick);
        end
        step(3);
        checks++;
        if (cnt !== 64'h55 || tick !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: cnt=%h tick=%b, want 55 0", cnt, tick);
        end
        timer_en = 1'b1;
        step(5);
        checks++;
        if (cnt !== 64'h59 || tick !== 1'b1) begin
            errors++;
            $display("FAIL rerun: cnt=%h tick=%b, want 59 1", cnt, tick);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        timer_en = 1'b0;
        checks++;
        if ({cnt, tick, ovf, halt_ack} !== 67'd0) begin
            errors++;
            $display("FAIL midrun_reset: cnt=%h tick=%b ovf=%b ack=%b, want all 0", cnt, tick, ovf, halt_ack);
        end
    endtask

    initial begin
        step(1);
        test_reset;
        test_nodiv;
        test_div;
        test_clamp;
        test_load_wrap;
        test_halt;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
